// File: rtl/dragonfang_pkg.sv
// rtl/dragonfang_pkg.sv - control state encodings for the compress unit
package dragonfang_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } compress_state_t;

endpackage

// File: rtl/riscv_v_pkg.sv
// rtl/riscv_v_pkg.sv - vector register length and element width code shared by vector units
package riscv_v_pkg;

  localparam int VLEN = 64;

  typedef enum logic [1:0] {
    SEW8  = 2'b00,
    SEW16 = 2'b01,
    SEW32 = 2'b10,
    SEW64 = 2'b11
  } vsew_t;

endpackage

// File: rtl/vector_element_select.sv
// rtl/vector_element_select.sv - returns element idx of a vector at a given width, zero-extended to 64 bits
module vector_element_select #(
  parameter int VLEN = riscv_v_pkg::VLEN
) (
  input  logic [VLEN-1:0]             vs2,
  input  logic [$clog2(VLEN/8):0]     idx,
  input  riscv_v_pkg::vsew_t          sew,
  output logic [63:0]                 elem
);

  // Pick the element slice for the current width; narrower elements are zero-extended.
  always_comb begin
    elem = '0;
    case (sew)
      riscv_v_pkg::SEW8:  elem = 64'(vs2[32'(idx)*8  +: 8]);
      riscv_v_pkg::SEW16: elem = 64'(vs2[32'(idx)*16 +: 16]);
      riscv_v_pkg::SEW32: elem = 64'(vs2[32'(idx)*32 +: 32]);
      riscv_v_pkg::SEW64: elem = vs2[32'(idx)*64 +: 64];
      default:            elem = '0;
    endcase
  end

endmodule

// File: rtl/vector_compress_unit.sv
// rtl/vector_compress_unit.sv - vector compress, one element per cycle; VCOMPRESS_TAIL_AGNOSTIC_EN selects ones-filled tail
module vector_compress_unit
  import dragonfang_pkg::*;
#(
  parameter int VLEN = riscv_v_pkg::VLEN
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [1:0]                  sew,
  input  logic [$clog2(VLEN/8):0]     vl,
  input  logic [VLEN-1:0]             vs2,
  input  logic [VLEN-1:0]             v0,
  input  logic [VLEN-1:0]             vd_old,
  output logic                        ready,
  output logic                        done,
  output logic [VLEN-1:0]             vd,
  output logic [$clog2(VLEN/8):0]     count
);

  localparam int CW = $clog2(VLEN/8) + 1;
  localparam int IW = $clog2(VLEN);

  compress_state_t    r_state, w_state_next;
  riscv_v_pkg::vsew_t r_sew;
  logic [CW-1:0]      r_n, r_idx, r_wp, r_count;
  logic [VLEN-1:0]    r_vs2, r_v0, r_work, r_vd;

  logic [CW-1:0]      w_vlmax, w_n_in, w_wp_next;
  logic [VLEN-1:0]    w_tail, w_work_next;
  logic [63:0]        w_elem;
  logic               w_sel, w_last;

`ifdef VCOMPRESS_TAIL_AGNOSTIC_EN
  logic w_unused_vd_old;
  assign w_unused_vd_old = ^vd_old;
  assign w_tail = '1;
`else
  assign w_tail = vd_old;
`endif

  // Elements that fit in the register at the requested width; vl is clamped to it.
  assign w_vlmax = CW'(VLEN/8) >> sew;
  assign w_n_in  = (vl > w_vlmax) ? w_vlmax : vl;
  assign w_sel   = r_v0[IW'(r_idx)];
  assign w_last  = (r_idx == r_n - CW'(1));

  vector_element_select #(.VLEN(VLEN)) u_select (
    .vs2  (r_vs2),
    .idx  (r_idx),
    .sew  (r_sew),
    .elem (w_elem)
  );

  // Pack the current element at the write pointer when its mask bit is set.
  always_comb begin
    w_work_next = r_work;
    w_wp_next   = r_wp;
    if (w_sel) begin
      w_wp_next = r_wp + CW'(1);
      case (r_sew)
        riscv_v_pkg::SEW8:  w_work_next[32'(r_wp)*8  +: 8]  = w_elem[7:0];
        riscv_v_pkg::SEW16: w_work_next[32'(r_wp)*16 +: 16] = w_elem[15:0];
        riscv_v_pkg::SEW32: w_work_next[32'(r_wp)*32 +: 32] = w_elem[31:0];
        default:            w_work_next[32'(r_wp)*64 +: 64] = w_elem;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    ready        = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) w_state_next = (w_n_in == '0) ? ST_DONE : ST_SCAN;
      end
      ST_SCAN: if (w_last) w_state_next = ST_DONE;
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Operand capture, scan progress and result publication; vd/count only change when an operation completes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sew   <= riscv_v_pkg::SEW8;
      r_n     <= '0;
      r_idx   <= '0;
      r_wp    <= '0;
      r_vs2   <= '0;
      r_v0    <= '0;
      r_work  <= '0;
      r_vd    <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_sew  <= riscv_v_pkg::vsew_t'(sew);
          r_n    <= w_n_in;
          r_vs2  <= vs2;
          r_v0   <= v0;
          r_work <= w_tail;
          r_idx  <= '0;
          r_wp   <= '0;
          if (w_n_in == '0) begin
            r_vd    <= w_tail;
            r_count <= '0;
          end
        end
        ST_SCAN: begin
          r_work <= w_work_next;
          r_wp   <= w_wp_next;
          r_idx  <= r_idx + CW'(1);
          if (w_last) begin
            r_vd    <= w_work_next;
            r_count <= w_wp_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign vd    = r_vd;
  assign count = r_count;

endmodule
